// File: rtl/bmp_stream_reader_pkg.sv
// Shared sizes for the BMP read-back path and the stream-length helper.
// Stream length depends on the optional BMP_STREAM_BITPACK_EN build macro.
package bmp_stream_reader_pkg;

    localparam int DEF_BYTE_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_HEADER_SIZE = 54;
    localparam int DEF_TOTAL_SIZE  = 118;
    localparam int DEF_FIFO_DEPTH  = 4;

    // Number of bytes the reader emits for a file of total_size bytes.
    function automatic int stream_length(input int header_size, input int total_size);
`ifdef BMP_STREAM_BITPACK_EN
        return header_size + (total_size - header_size + 7) / 8;
`else
        return total_size;
`endif
    endfunction

endpackage

// File: rtl/bmp_stream_reader_out_fifo.sv
// Output buffer of the BMP stream reader: DEPTH entries of {last, data},
// head entry presented combinationally, data forced to zero while empty.
module bmp_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_push_last,
    input  logic                         i_pop,
    output logic                         o_valid,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_last,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;
    logic [WIDTH:0]     w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= {i_push_last, i_push_data};
    end

    assign w_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? w_head[WIDTH-1:0] : '0;
    assign o_last  = o_valid && w_head[WIDTH];
    assign o_count = r_count;

endmodule

// File: rtl/bmp_stream_reader.sv
// Streams the stored BMP out of image RAM as a valid/ready byte stream.
// Build macro BMP_STREAM_BITPACK_EN packs pixel bytes 8:1 (header kept verbatim).
module bmp_stream_reader
    import bmp_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int BYTE_WIDTH  = DEF_BYTE_WIDTH,
    parameter int HEADER_SIZE = DEF_HEADER_SIZE,
    parameter int TOTAL_SIZE  = DEF_TOTAL_SIZE,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BYTE_WIDTH-1:0]   RAM_Q,
    output logic                    RAM_ren,
    output logic [ADDR_WIDTH-1:0]   RAM_addr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [1:0]             r_inflight;
    logic                   r_cap_vld;
    logic                   r_cap_last;
    logic                   w_issue;
    logic                   w_credit;
    logic [OCC_W-1:0]       w_occ;
    logic                   w_pend;
    logic                   w_push;
    logic [BYTE_WIDTH-1:0]  w_push_data;
    logic                   w_push_last;
    logic                   w_pop;
    logic [CNT_W-1:0]       w_fifo_count;

    // Pending pack byte reserves a FIFO slot so the final flush can never overflow.
    assign w_occ    = OCC_W'(w_fifo_count) + OCC_W'(r_inflight) + OCC_W'(w_pend);
    assign w_credit = (w_occ < OCC_W'(FIFO_DEPTH));
    assign w_pop    = out_valid && out_ready;

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_READ;
            end
            ST_READ: begin
                busy    = 1'b1;
                w_issue = w_credit;
                if (w_issue && (r_addr == LAST_ADDR)) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if ((w_fifo_count == '0) && (r_inflight == 2'd0) && !w_pend)
                    w_next_state = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_inflight <= 2'd0;
            r_cap_vld  <= 1'b0;
            r_cap_last <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cap_vld  <= w_issue;
            r_cap_last <= w_issue && (r_addr == LAST_ADDR);
            if ((r_state == ST_IDLE) && start)
                r_addr <= '0;
            else if (w_issue)
                r_addr <= r_addr + ADDR_WIDTH'(1);
            case ({w_issue, r_cap_vld})
                2'b10:   r_inflight <= r_inflight + 2'd1;
                2'b01:   r_inflight <= r_inflight - 2'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign RAM_ren  = w_issue;
    assign RAM_addr = r_addr;

`ifdef BMP_STREAM_BITPACK_EN
    localparam int PK_W = $clog2(BYTE_WIDTH);
    localparam logic [PK_W-1:0] PK_MAX = PK_W'(BYTE_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] HDR_END = ADDR_WIDTH'(HEADER_SIZE);

    logic                   r_cap_hdr;
    logic [BYTE_WIDTH-1:0]  r_pack;
    logic [PK_W-1:0]        r_pack_cnt;
    logic                   w_bit;
    logic [BYTE_WIDTH-1:0]  w_pack_val;
    logic                   w_flush;

    // First pixel lands in the MSB.
    assign w_bit      = |RAM_Q;
    assign w_pack_val = r_pack | ({{(BYTE_WIDTH-1){1'b0}}, w_bit} << (PK_MAX - r_pack_cnt));
    assign w_flush    = (r_pack_cnt == PK_MAX) || r_cap_last;
    assign w_pend     = (r_pack_cnt != '0);

    always_comb begin
        w_push      = 1'b0;
        w_push_data = RAM_Q;
        w_push_last = r_cap_last;
        if (r_cap_vld) begin
            if (r_cap_hdr) begin
                w_push = 1'b1;
            end else if (w_flush) begin
                w_push      = 1'b1;
                w_push_data = w_pack_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_hdr  <= 1'b0;
            r_pack     <= '0;
            r_pack_cnt <= '0;
        end else begin
            r_cap_hdr <= (r_addr < HDR_END);
            if (r_cap_vld && !r_cap_hdr) begin
                if (w_flush) begin
                    r_pack     <= '0;
                    r_pack_cnt <= '0;
                end else begin
                    r_pack     <= w_pack_val;
                    r_pack_cnt <= r_pack_cnt + PK_W'(1);
                end
            end
        end
    end
`else
    assign w_pend      = 1'b0;
    assign w_push      = r_cap_vld;
    assign w_push_data = RAM_Q;
    assign w_push_last = r_cap_last;
`endif

    bmp_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_WIDTH)
    ) u_out_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_push_last (w_push_last),
        .i_pop       (w_pop),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_last      (out_last),
        .o_count     (w_fifo_count)
    );

endmodule

// File: tb/tb_bmp_stream_reader.sv
// Scoreboard bench for bmp_stream_reader: stimulus queues expected bytes,
// a negedge monitor pops and compares every transfer.
module tb_bmp_stream_reader;
    import bmp_stream_reader_pkg::*;

    localparam int BW    = DEF_BYTE_WIDTH;
    localparam int AW    = DEF_ADDR_WIDTH;
    localparam int HDR   = DEF_HEADER_SIZE;
    localparam int TOTAL = DEF_TOTAL_SIZE;
    localparam int DEPTH = DEF_FIFO_DEPTH;
    localparam int SLEN  = stream_length(HDR, TOTAL);
`ifdef BMP_STREAM_BITPACK_EN
    localparam int RST_AT = 40;
`else
    localparam int RST_AT = 100;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [BW-1:0] ram_q;
    logic          RAM_ren;
    logic [AW-1:0] RAM_addr;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    bmp_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .RAM_Q     (ram_q),
        .RAM_ren   (RAM_ren),
        .RAM_addr  (RAM_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [BW-1:0] mem [TOTAL];
    always @(posedge clk) begin
        if (RAM_ren) ram_q <= (int'(RAM_addr) < TOTAL) ? mem[RAM_addr] : '0;
    end

    logic [BW:0] exp_q [$];
    int n_chk  = 0;
    int n_pass = 0;
    int exp_addr, issued, xfer, done_cnt, cyc, last_xfer_cyc;
    bit chk_thru  = 1'b0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Expected stream straight from the RAM image: header verbatim, pixels verbatim or packed.
    task automatic load_expected();
        exp_q.delete();
`ifdef BMP_STREAM_BITPACK_EN
        begin
            logic [BW-1:0] pk;
            int nb;
            for (int i = 0; i < HDR; i++) exp_q.push_back({1'b0, mem[i]});
            pk = '0;
            nb = 0;
            for (int i = HDR; i < TOTAL; i++) begin
                if (mem[i] != '0) pk[BW-1-nb] = 1'b1;
                nb++;
                if (nb == BW || i == TOTAL - 1) begin
                    exp_q.push_back({(i == TOTAL - 1), pk});
                    pk = '0;
                    nb = 0;
                end
            end
        end
`else
        for (int i = 0; i < TOTAL; i++) exp_q.push_back({(i == TOTAL - 1), mem[i]});
`endif
    endtask

    // Out_ready: held high, or a fresh coin flip each cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor.
    initial begin
        bit          held_vld;
        logic [BW:0] held;
        logic [BW:0] e;
        held_vld = 1'b0;
        held     = '0;
        cyc      = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (RAM_ren) begin
                    check("rd_addr", 32'(RAM_addr), 32'(exp_addr));
`ifndef BMP_STREAM_BITPACK_EN
                    check("credit", 32'((issued - xfer) < DEPTH), 32'd1);
`endif
                    exp_addr++;
                    issued++;
                end
                if (held_vld) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'({out_last, out_data}), 32'(held));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL extra_byte: got 0x%0h expected no byte", {out_last, out_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'({out_last, out_data}), 32'(e));
                    end
`ifdef BMP_STREAM_BITPACK_EN
                    if (xfer == HDR) check("packed_b1", 32'(out_data), 32'h0000_00B1);
`endif
                    if (chk_thru && xfer > 0) check("thru_gap", 32'(cyc - last_xfer_cyc), 32'd1);
                    last_xfer_cyc = cyc;
                    xfer++;
                end
                held_vld = out_valid && !out_ready;
                held     = {out_last, out_data};
                if (done) begin
                    done_cnt++;
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end else begin
                held_vld = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ren"},   32'(RAM_ren),   32'd0);
        check({tag, "_addr"},  32'(RAM_addr),  32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  32'(out_data),  32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
    endtask

    // Pulse start and verify the k+1 read / k+3 valid latency.
    task automatic start_stream();
        load_expected();
        exp_addr = 0;
        issued   = 0;
        xfer     = 0;
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("lat_ren_k1", 32'(RAM_ren), 32'd1);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_valid_k1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid_k2", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid_k3", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_cnt == 0) begin
            n_chk++;
            $display("FAIL done_timeout: got no done after %0d cycles expected a done pulse", max_cycles);
        end
        repeat (4) @(posedge clk);
        #1;
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("bytes_out", 32'(xfer), 32'(SLEN));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("reads_issued", 32'(issued), 32'(TOTAL));
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < TOTAL; i++) begin
`ifdef BMP_STREAM_BITPACK_EN
            logic [7:0] pat [8];
            pat = '{8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255};
            mem[i] = (i < HDR) ? BW'(i) : pat[(i - HDR) % 8];
`else
            mem[i] = BW'(i);
`endif
        end
        start = 1'b0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // In-order stream with out_ready held high.
        ready_mode = 0;
`ifndef BMP_STREAM_BITPACK_EN
        chk_thru = 1'b1;
`endif
        start_stream();
        wait_done(1000);
        chk_thru = 1'b0;

        // Random back-pressure.
        ready_mode = 1;
        start_stream();
        wait_done(4000);

        // Start while busy is ignored; start after done restarts at 0.
        ready_mode = 0;
        start_stream();
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1000);
        start_stream();
        wait_done(1000);

        // Asynchronous reset mid-stream, then a full restart.
        start_stream();
        begin
            int n;
            n = 0;
            while (xfer < RST_AT && n < 1000) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (xfer < RST_AT) begin
                n_chk++;
                $display("FAIL mid_reset_timeout: got %0d transfers expected %0d", xfer, RST_AT);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start_stream();
        wait_done(1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
